// File: rtl/reg_file_cmd_ctrl.sv
// rtl/reg_file_cmd_ctrl.sv - byte-stream command parser driving a register file, with serialised read-back
module reg_file_cmd_ctrl #(
    parameter int         MEM_WIDTH = 16,
    parameter int         MEM_DEPTH = 8,
    parameter logic [7:0] WR_OP     = 8'hAA,
    parameter logic [7:0] RD_OP     = 8'hBB,
    localparam int        NB        = MEM_WIDTH / 8,
    localparam int        AW        = $clog2(MEM_DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           RX_Data,
    input  logic                 RX_Valid,
    input  logic [MEM_WIDTH-1:0] RdData,
    input  logic                 TX_Ready,
    output logic                 WrEn,
    output logic                 RdEn,
    output logic [AW-1:0]        Address,
    output logic [MEM_WIDTH-1:0] WrData,
    output logic [7:0]           TX_Data,
    output logic                 TX_Valid,
    output logic                 Busy,
    output logic                 Cmd_Err
);

    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
    localparam logic [8:0]    DEPTH9   = 9'(MEM_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_WR_EXEC  = 3'd3;
    localparam logic [2:0] S_RD_EXEC  = 3'd4;
    localparam logic [2:0] S_RD_WAIT  = 3'd5;
    localparam logic [2:0] S_TX       = 3'd6;

    logic [2:0]           state;
    logic                 op_rd;
    logic [CW-1:0]        byte_cnt;
    logic [MEM_WIDTH-1:0] shift;
    logic [MEM_WIDTH-1:0] shift_nxt;

    assign shift_nxt = shift >> 8;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            op_rd    <= 1'b0;
            byte_cnt <= '0;
            shift    <= '0;
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            Address  <= '0;
            WrData   <= '0;
            TX_Data  <= '0;
            TX_Valid <= 1'b0;
            Busy     <= 1'b0;
            Cmd_Err  <= 1'b0;
        end else begin
            Cmd_Err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (RX_Valid) begin
                        if (RX_Data == WR_OP || RX_Data == RD_OP) begin
                            op_rd <= (RX_Data == RD_OP);
                            state <= S_GET_ADDR;
                        end else begin
                            Cmd_Err <= 1'b1;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (RX_Valid) begin
                        // Out-of-range addresses abort the command before any register access
                        if ({1'b0, RX_Data} >= DEPTH9) begin
                            Cmd_Err <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            Address <= RX_Data[AW-1:0];
                            if (op_rd) begin
                                RdEn  <= 1'b1;
                                Busy  <= 1'b1;
                                state <= S_RD_EXEC;
                            end else begin
                                byte_cnt <= '0;
                                state    <= S_GET_DATA;
                            end
                        end
                    end
                end
                S_GET_DATA: begin
                    if (RX_Valid) begin
                        WrData[8*byte_cnt +: 8] <= RX_Data;
                        if (byte_cnt == CNT_LAST) begin
                            byte_cnt <= '0;
                            WrEn     <= 1'b1;
                            Busy     <= 1'b1;
                            state    <= S_WR_EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                S_WR_EXEC: begin
                    Cmd_Err <= RX_Valid;
                    WrEn    <= 1'b0;
                    Busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                S_RD_EXEC: begin
                    Cmd_Err <= RX_Valid;
                    RdEn    <= 1'b0;
                    state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    Cmd_Err  <= RX_Valid;
                    shift    <= RdData;
                    TX_Data  <= RdData[7:0];
                    TX_Valid <= 1'b1;
                    byte_cnt <= '0;
                    state    <= S_TX;
                end
                S_TX: begin
                    Cmd_Err <= RX_Valid;
                    // Data and valid only move on acceptance, so backpressure holds them stable
                    if (TX_Valid && TX_Ready) begin
                        if (byte_cnt == CNT_LAST) begin
                            TX_Valid <= 1'b0;
                            Busy     <= 1'b0;
                            byte_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            shift    <= shift_nxt;
                            TX_Data  <= shift_nxt[7:0];
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// tb/tb_reg_file_cmd_ctrl.sv - self-checking bench for reg_file_cmd_ctrl with a register-file model
module tb_reg_file_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_Data;
    logic        RX_Valid;
    logic [15:0] RdData;
    logic        TX_Ready;
    logic        WrEn;
    logic        RdEn;
    logic [2:0]  Address;
    logic [15:0] WrData;
    logic [7:0]  TX_Data;
    logic        TX_Valid;
    logic        Busy;
    logic        Cmd_Err;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    logic [15:0] rf_mem  [8];
    logic [15:0] exp_mem [8];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          got_cyc [$];

    reg_file_cmd_ctrl #(
        .MEM_WIDTH(16),
        .MEM_DEPTH(8),
        .WR_OP(8'hAA),
        .RD_OP(8'hBB)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_Data(RX_Data),
        .RX_Valid(RX_Valid),
        .RdData(RdData),
        .TX_Ready(TX_Ready),
        .WrEn(WrEn),
        .RdEn(RdEn),
        .Address(Address),
        .WrData(WrData),
        .TX_Data(TX_Data),
        .TX_Valid(TX_Valid),
        .Busy(Busy),
        .Cmd_Err(Cmd_Err)
    );

    always #5 CLK = ~CLK;

    // Register file: synchronous write, one-cycle registered read
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (WrEn) rf_mem[Address] <= WrData;
        if (RdEn) RdData <= rf_mem[Address];
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (WrEn) wr_cnt++;
            if (RdEn) rd_cnt++;
            if (Cmd_Err) err_cnt++;
            if (TX_Valid && TX_Ready) begin
                got_q.push_back(TX_Data);
                got_cyc.push_back(cyc);
            end
            if (WrEn || RdEn) begin
                n_cmp++;
                if (WrEn && RdEn) begin
                    n_err++;
                    $display("FAIL wr_rd_exclusive got WrEn=%b RdEn=%b exp not both", WrEn, RdEn);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        RX_Data  = b;
        RX_Valid = 1'b1;
        @(posedge CLK);
        #1;
        RX_Valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        send_byte(8'hAA);
        send_byte({5'b0, a});
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        exp_mem[a] = d;
    endtask

    task automatic do_read(input logic [2:0] a);
        send_byte(8'hBB);
        send_byte({5'b0, a});
        exp_q.push_back(exp_mem[a][7:0]);
        exp_q.push_back(exp_mem[a][15:8]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        n_cmp++;
        if (n >= 100) begin
            n_err++;
            $display("FAIL wait_idle got Busy=1 after %0d cycles exp Busy=0", n);
        end
    endtask

    task automatic wait_tx_valid();
        int n = 0;
        while (!TX_Valid && n < 50) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++;
        if (n >= 50) begin
            n_err++;
            $display("FAIL wait_tx_valid got TX_Valid=0 exp 1 within 50 cycles");
        end
    endtask

    task automatic check_tx(input string name);
        logic [7:0] e;
        logic [7:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s tx_byte got none exp %h", name, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL %s tx_byte got %h exp %h", name, g, e);
                end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_err++;
            $display("FAIL %s tx_extra got %0d extra bytes exp 0", name, got_q.size());
        end
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        RX_Valid = 1'b0;
        RX_Data  = 8'h00;
        TX_Ready = 1'b1;
        RdData   = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            rf_mem[i]  = 16'h0000;
            exp_mem[i] = 16'h0000;
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({WrEn, RdEn, Address, WrData, TX_Data, TX_Valid, Busy, Cmd_Err} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h exp 0",
                     {WrEn, RdEn, Address, WrData, TX_Data, TX_Valid, Busy, Cmd_Err});
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_write();
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        int e0 = err_cnt;
        do_write(3'd3, 16'hFF0F);
        @(negedge CLK);
        n_cmp++;
        if ({WrEn, Address, WrData} !== {1'b1, 3'd3, 16'hFF0F}) begin
            n_err++;
            $display("FAIL write_pins got WrEn=%b Address=%0d WrData=%h exp 1 3 ff0f", WrEn, Address, WrData);
        end
        @(posedge CLK);
        #1;
        wait_idle();
        n_cmp++;
        if ((wr_cnt - w0) != 1 || (rd_cnt - r0) != 0 || (err_cnt - e0) != 0) begin
            n_err++;
            $display("FAIL write_counts got wr=%0d rd=%0d err=%0d exp 1 0 0", wr_cnt - w0, rd_cnt - r0, err_cnt - e0);
        end
    endtask

    task automatic test_read();
        int r0 = rd_cnt;
        TX_Ready = 1'b1;
        do_read(3'd3);
        @(negedge CLK);
        n_cmp++;
        if (RdEn !== 1'b1 || TX_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL read_e1 got RdEn=%b TX_Valid=%b exp 1 0", RdEn, TX_Valid);
        end
        @(negedge CLK);
        n_cmp++;
        if (TX_Valid !== 1'b0 || RdEn !== 1'b0) begin
            n_err++;
            $display("FAIL read_e2 got RdEn=%b TX_Valid=%b exp 0 0", RdEn, TX_Valid);
        end
        @(negedge CLK);
        n_cmp++;
        if (TX_Valid !== 1'b1 || TX_Data !== 8'h0F) begin
            n_err++;
            $display("FAIL read_tx_first got valid=%b data=%h exp 1 0f", TX_Valid, TX_Data);
        end
        @(posedge CLK);
        #1;
        wait_idle();
        n_cmp++;
        if (got_cyc.size() != 2 || (got_cyc[1] - got_cyc[0]) != 1) begin
            n_err++;
            $display("FAIL read_consecutive got %0d bytes exp 2 on consecutive cycles", got_cyc.size());
        end
        n_cmp++;
        if (Busy !== 1'b0 || (rd_cnt - r0) != 1) begin
            n_err++;
            $display("FAIL read_done got Busy=%b rd=%0d exp 0 1", Busy, rd_cnt - r0);
        end
        check_tx("read_back");
    endtask

    task automatic test_backpressure();
        TX_Ready = 1'b0;
        do_read(3'd3);
        wait_tx_valid();
        repeat (5) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_Valid !== 1'b1 || TX_Data !== 8'h0F) begin
                n_err++;
                $display("FAIL backpressure_hold got valid=%b data=%h exp 1 0f", TX_Valid, TX_Data);
            end
        end
        @(posedge CLK);
        #1;
        TX_Ready = 1'b1;
        wait_idle();
        check_tx("backpressure");
    endtask

    task automatic test_errors();
        int w0;
        send_byte(8'h55);
        @(negedge CLK);
        n_cmp++;
        if (Cmd_Err !== 1'b1) begin
            n_err++;
            $display("FAIL err_bad_opcode got %b exp 1", Cmd_Err);
        end
        @(posedge CLK);
        #1;
        w0 = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h09);
        @(negedge CLK);
        n_cmp++;
        if (Cmd_Err !== 1'b1) begin
            n_err++;
            $display("FAIL err_bad_addr got %b exp 1", Cmd_Err);
        end
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (wr_cnt != w0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL err_bad_addr_nowrite got wr=%0d Busy=%b exp 0 0", wr_cnt - w0, Busy);
        end
        TX_Ready = 1'b0;
        do_read(3'd3);
        wait_tx_valid();
        @(posedge CLK);
        #1;
        send_byte(8'h77);
        @(negedge CLK);
        n_cmp++;
        if (Cmd_Err !== 1'b1 || TX_Valid !== 1'b1 || TX_Data !== 8'h0F) begin
            n_err++;
            $display("FAIL err_during_tx got err=%b valid=%b data=%h exp 1 1 0f", Cmd_Err, TX_Valid, TX_Data);
        end
        @(posedge CLK);
        #1;
        TX_Ready = 1'b1;
        wait_idle();
        check_tx("err_during_tx");
    endtask

    task automatic test_reset_mid();
        int w0 = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h12);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        do_write(3'd5, 16'h1234);
        @(negedge CLK);
        n_cmp++;
        if (WrEn !== 1'b1 || WrData !== 16'h1234) begin
            n_err++;
            $display("FAIL reset_mid_write got WrEn=%b WrData=%h exp 1 1234", WrEn, WrData);
        end
        @(posedge CLK);
        #1;
        wait_idle();
        n_cmp++;
        if ((wr_cnt - w0) != 1) begin
            n_err++;
            $display("FAIL reset_mid_count got %0d writes exp 1", wr_cnt - w0);
        end
        TX_Ready = 1'b1;
        do_read(3'd5);
        wait_idle();
        check_tx("reset_mid_readback");
        TX_Ready = 1'b0;
        send_byte(8'hBB);
        send_byte(8'h05);
        wait_tx_valid();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (TX_Valid !== 1'b0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_during_tx got valid=%b busy=%b exp 0 0", TX_Valid, Busy);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        TX_Ready = 1'b1;
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_sweep();
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        logic [7:0] hi;
        logic [7:0] lo;
        for (int i = 0; i < 8; i++) begin
            hi = 8'hA0 + 8'(i);
            lo = 8'h50 + 8'(i);
            do_write(3'(i), {hi, lo});
            wait_idle();
        end
        TX_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            wait_idle();
            check_tx("sweep");
        end
        n_cmp++;
        if ((wr_cnt - w0) != 8 || (rd_cnt - r0) != 8) begin
            n_err++;
            $display("FAIL sweep_counts got wr=%0d rd=%0d exp 8 8", wr_cnt - w0, rd_cnt - r0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_sweep();
        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
